// File: rtl/lvds_pll_rst_seq.sv
// ---------------------------------------------------------------------------
// lvds_pll_rst_seq
//
// Reset/lock sequencer for the LVDS PLL. It runs on the free-running
// reference clock, so it keeps working while the PLL is unlocked. It pulses
// the PLL reset, waits for a synchronized lock, requires lock to be stable
// for STABLE_CYCLES, and then releases the LVDS datapath reset. The PLL is
// reset again on a lock timeout, on loss of lock while running, or on a
// software relock request. Lock losses seen while running are counted.
//
// Ports:
//   refclk        in   reference clock; all logic uses its rising edge
//   rst           in   synchronous active-high reset
//   pll_locked    in   PLL lock indicator, asynchronous to refclk
//   relock_req    in   single-cycle relock request, honoured only in RUN
//   pll_rst       out  PLL reset, active high
//   sys_rst       out  LVDS datapath reset, active high
//   ready         out  high only in RUN
//   loss_count    out  saturating count of lock losses seen in RUN
//   state         out  PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3
//   timeout_count out  (only with LVDS_PLL_RST_SEQ_TIMEOUT_CNT_EN defined)
//                      saturating count of WAIT_LOCK timeouts
//
// Optional feature macro: LVDS_PLL_RST_SEQ_TIMEOUT_CNT_EN
// ---------------------------------------------------------------------------
module lvds_pll_rst_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOSS_CNT_W     = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic                  sys_rst,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic [1:0]            state
`ifdef LVDS_PLL_RST_SEQ_TIMEOUT_CNT_EN
    ,
    output logic [7:0]            timeout_count
`endif
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // One shared cycle counter serves all three timed states; it is sized
    // for the largest of them and every state leaves at its terminal value,
    // so it never wraps.
    localparam int MAX_AB  = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    logic             lock_meta;
    logic             lock_s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             count_loss;

    // Two-flop synchronizer for the asynchronous PLL lock signal. Nothing
    // else in the block looks at pll_locked directly.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Next-state and counter logic. Each timed state compares the counter
    // against (cycles - 1) so the state lasts exactly the configured number
    // of cycles, and every transition clears the counter for the next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        count_loss = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                // A lock loss wins over a simultaneous relock request so the
                // loss is still counted exactly once.
                if (!lock_s) begin
                    state_d    = S_PLL_RST;
                    cnt_d      = '0;
                    count_loss = 1'b1;
                end else if (relock_req) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // State register plus registered outputs. The outputs are decoded from
    // the next state so they change on the same edge as the state itself.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= S_PLL_RST;
            cnt_q      <= '0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            loss_count <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pll_rst <= (state_d == S_PLL_RST);
            sys_rst <= (state_d != S_RUN);
            ready   <= (state_d == S_RUN);
            if (count_loss && (loss_count != {LOSS_CNT_W{1'b1}})) begin
                loss_count <= loss_count + LOSS_CNT_W'(1);
            end
        end
    end

    assign state = state_q;

`ifdef LVDS_PLL_RST_SEQ_TIMEOUT_CNT_EN
    // The only way out of WAIT_LOCK back to PLL_RST is a timeout, so that
    // transition alone identifies a timeout event.
    always_ff @(posedge refclk) begin
        if (rst) begin
            timeout_count <= '0;
        end else if ((state_q == S_WAIT_LOCK) && (state_d == S_PLL_RST) &&
                     (timeout_count != 8'hFF)) begin
            timeout_count <= timeout_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lvds_pll_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_lvds_pll_rst_seq
//
// Self-checking bench for lvds_pll_rst_seq with PLL_RST_CYCLES=4,
// STABLE_CYCLES=8, LOCK_TIMEOUT=32 and LOSS_CNT_W=2. A table of per-cycle
// vectors covers reset and the first lock sequence; hand-written sequences
// cover lock loss, relock, STABLE glitches, timeouts, saturation and a
// mid-sequence reset.
// ---------------------------------------------------------------------------
module tb_lvds_pll_rst_seq;

    localparam int LW = 2;

    logic          refclk     = 1'b0;
    logic          rst        = 1'b1;
    logic          pll_locked = 1'b0;
    logic          relock_req = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic [LW-1:0] loss_count;
    logic [1:0]    state;
`ifdef LVDS_PLL_RST_SEQ_TIMEOUT_CNT_EN
    logic [7:0]    timeout_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    lvds_pll_rst_seq #(
        .PLL_RST_CYCLES (4),
        .STABLE_CYCLES  (8),
        .LOCK_TIMEOUT   (32),
        .LOSS_CNT_W     (LW)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .loss_count    (loss_count),
        .state         (state)
`ifdef LVDS_PLL_RST_SEQ_TIMEOUT_CNT_EN
        ,
        .timeout_count (timeout_count)
`endif
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic          rst;
        logic          locked;
        logic          relock;
        logic [1:0]    exp_state;
        logic          exp_pll_rst;
        logic          exp_sys_rst;
        logic          exp_ready;
        logic [LW-1:0] exp_loss;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic r, input logic l, input logic q,
                                input logic [1:0] st, input logic pr,
                                input logic sr, input logic rdy,
                                input logic [LW-1:0] loss);
        vec_t v;
        v.rst = r; v.locked = l; v.relock = q;
        v.exp_state = st; v.exp_pll_rst = pr; v.exp_sys_rst = sr;
        v.exp_ready = rdy; v.exp_loss = loss;
        return v;
    endfunction

    // Drive inputs, then let one active edge pass and settle 1 ns after it.
    task automatic applyStimulus(input logic r, input logic l, input logic q);
        rst        = r;
        pll_locked = l;
        relock_req = q;
        @(posedge refclk);
        #1;
    endtask

    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [1:0] es,
                               input logic epr, input logic esr,
                               input logic erdy, input logic [LW-1:0] el);
        tests_run++;
        if ({state, pll_rst, sys_rst, ready, loss_count} !== {es, epr, esr, erdy, el}) begin
            tests_failed++;
            $display("[TB] FAIL %s: got state=%0d pll_rst=%b sys_rst=%b ready=%b loss_count=%0d; expected state=%0d pll_rst=%b sys_rst=%b ready=%b loss_count=%0d",
                     name, state, pll_rst, sys_rst, ready, loss_count,
                     es, epr, esr, erdy, el);
        end
    endtask

    // Expected outputs follow directly from the state that should be held.
    task automatic checkState(input string name, input logic [1:0] st,
                              input logic [LW-1:0] loss);
        checkOutput(name, st, st == 2'd0, st != 2'd3, st == 2'd3, loss);
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitState(input string name, input logic [1:0] target, input int budget);
        int n = 0;
        while (state !== target && n < budget) begin
            @(posedge refclk);
            #1;
            n++;
        end
        tests_run++;
        if (state !== target) begin
            tests_failed++;
            $display("[TB] FAIL %s: state=%0d after %0d cycles, expected %0d", name, state, n, target);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sys_low;
        int pr_pulses;
        logic prev_pr;

        // Reset for two edges, then lock rises on WAIT_LOCK entry; a relock
        // request in WAIT_LOCK (vector 7) must be ignored.
        vecs[0]  = mk(1, 0, 0, 2'd0, 1, 1, 0, 0);
        vecs[1]  = mk(1, 0, 1, 2'd0, 1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 2'd0, 1, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 2'd0, 1, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 2'd0, 1, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 2'd1, 0, 1, 0, 0);
        vecs[6]  = mk(0, 1, 0, 2'd1, 0, 1, 0, 0);
        vecs[7]  = mk(0, 1, 1, 2'd1, 0, 1, 0, 0);
        vecs[8]  = mk(0, 1, 0, 2'd2, 0, 1, 0, 0);
        for (int i = 9; i <= 15; i++) vecs[i] = mk(0, 1, 0, 2'd2, 0, 1, 0, 0);
        vecs[16] = mk(0, 1, 0, 2'd3, 0, 0, 1, 0);
        vecs[17] = mk(0, 1, 0, 2'd3, 0, 0, 1, 0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].locked, vecs[i].relock);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_pll_rst,
                        vecs[i].exp_sys_rst, vecs[i].exp_ready, vecs[i].exp_loss);
        end

        // One-cycle lock drop in RUN: sys_rst rises on the 3rd edge.
        applyStimulus(0, 0, 0);
        checkState("drop_edge1", 2'd3, 0);
        applyStimulus(0, 1, 0);
        checkState("drop_edge2", 2'd3, 0);
        applyStimulus(0, 1, 0);
        checkState("drop_edge3", 2'd0, 1);
        stepCycles(3);
        checkState("reseq_pll_rst_last", 2'd0, 1);
        stepCycles(1);
        checkState("reseq_wait_lock", 2'd1, 1);
        stepCycles(1);
        checkState("reseq_stable", 2'd2, 1);
        stepCycles(7);
        checkState("reseq_stable_end", 2'd2, 1);
        stepCycles(1);
        checkState("reseq_run", 2'd3, 1);

        // Relock request in RUN, then a lock glitch seen in STABLE at count 5.
        applyStimulus(0, 1, 1);
        checkState("relock_run", 2'd0, 1);
        applyStimulus(0, 1, 0);
        stepCycles(3);
        checkState("relock_wait_lock", 2'd1, 1);
        stepCycles(1);
        checkState("relock_stable", 2'd2, 1);
        stepCycles(3);
        applyStimulus(0, 0, 0);
        checkState("glitch_cnt4", 2'd2, 1);
        applyStimulus(0, 1, 0);
        checkState("glitch_cnt5", 2'd2, 1);
        applyStimulus(0, 1, 0);
        checkState("glitch_back_wait", 2'd1, 1);
        stepCycles(1);
        checkState("glitch_restable", 2'd2, 1);
        stepCycles(7);
        checkState("glitch_fresh7", 2'd2, 1);
        stepCycles(1);
        checkState("glitch_run", 2'd3, 1);

        // Lock lost for good: relock ignored in WAIT_LOCK, then 3 timeouts.
        applyStimulus(0, 0, 0);
        stepCycles(2);
        checkState("loss_two", 2'd0, 2);
        stepCycles(4);
        checkState("nolock_wait", 2'd1, 2);
        applyStimulus(0, 0, 1);
        checkState("relock_ignored", 2'd1, 2);
        sys_low   = 0;
        pr_pulses = 0;
        prev_pr   = pll_rst;
        for (int d = 9; d <= 111; d++) begin
            applyStimulus(0, 0, 0);
            if (sys_rst !== 1'b1) sys_low++;
            if (pll_rst === 1'b1 && prev_pr === 1'b0) pr_pulses++;
            prev_pr = pll_rst;
            case (d)
                38, 74, 110: checkState($sformatf("timeout_wait_d%0d", d), 2'd1, 2);
                39, 75, 111: checkState($sformatf("timeout_rst_d%0d", d), 2'd0, 2);
                42:          checkState("timeout_rst_last", 2'd0, 2);
                43:          checkState("timeout_rewait", 2'd1, 2);
                default: ;
            endcase
        end
        checkValue("sys_rst_low_cycles", sys_low, 0);
        checkValue("pll_rst_pulses", pr_pulses, 3);
`ifdef LVDS_PLL_RST_SEQ_TIMEOUT_CNT_EN
        checkValue("timeout_count", int'(timeout_count), 3);
`endif

        // Three more losses: the 2-bit counter saturates at 3.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0);
            waitState($sformatf("sat_reach_run%0d", k), 2'd3, 60);
            applyStimulus(0, 0, 0);
            stepCycles(2);
            checkState($sformatf("sat_loss%0d", k), 2'd0, 3);
        end

        // Reset asserted mid-STABLE returns everything to reset values.
        applyStimulus(0, 1, 0);
        waitState("reach_stable", 2'd2, 40);
        stepCycles(3);
        applyStimulus(1, 1, 0);
        checkState("rst_mid_stable", 2'd0, 0);
`ifdef LVDS_PLL_RST_SEQ_TIMEOUT_CNT_EN
        checkValue("timeout_count_rst", int'(timeout_count), 0);
`endif
        applyStimulus(0, 1, 0);
        stepCycles(2);
        checkState("post_rst_pll_rst", 2'd0, 0);
        stepCycles(1);
        checkState("post_rst_wait", 2'd1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
